// File: rtl/downcount_monitor.sv
// downcount_monitor: checks a down-counting sequence, counts wraps and errors,
// and queues wrap/error events in a small FIFO for a downstream consumer.
module downcount_monitor #(
   parameter int WIDTH  = 4,
   parameter int WRAP_W = 8,
   parameter int ERR_W  = 4,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  count_in,
   input  logic              in_valid,
   input  logic              clear_err,
   output logic              wrap_pulse,
   output logic [WRAP_W-1:0] wrap_count,
   output logic              err_flag,
   output logic [ERR_W-1:0]  err_count,
   output logic              ovf_flag,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [WRAP_W:0]   evt_data
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [1:0] {ACQUIRE, TRACK, FAULT} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] prev;
   logic [WRAP_W:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0] used;
   logic sample, check, match, wrap, mism, push, pop, full, accept, drop;
   logic [WRAP_W:0] evt_in;
   always_comb begin
      sample  = in_valid && !clear_err;
      check   = sample && state != ACQUIRE;
      match   = count_in == prev - WIDTH'(1);
      wrap    = check && match && prev == '0;
      mism    = check && !match;
      push    = wrap || (mism && state == TRACK);
      pop     = evt_valid && evt_ready;
      full    = used == (AW+1)'(DEPTH);
      accept  = push && (!full || pop);
      drop    = push && full && !pop;
      evt_in  = wrap ? {1'b0, wrap_count + WRAP_W'(1)} : {1'b1, WRAP_W'(count_in)};
      state_n = clear_err ? ACQUIRE : !sample ? state : state == ACQUIRE ? TRACK : mism ? FAULT : state;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= ACQUIRE;
         prev       <= '0;
         wrap_pulse <= 1'b0;
         wrap_count <= '0;
         err_flag   <= 1'b0;
         err_count  <= '0;
         ovf_flag   <= 1'b0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         used       <= '0;
      end else begin
         state      <= state_n;
         wrap_pulse <= wrap;
         err_flag   <= !clear_err && (err_flag || mism);
         ovf_flag   <= !clear_err && (ovf_flag || drop);
         used       <= used + (AW+1)'(accept) - (AW+1)'(pop);
         if (sample) prev <= count_in;
         if (wrap) wrap_count <= wrap_count + WRAP_W'(1);
         if (mism && err_count != '1) err_count <= err_count + ERR_W'(1);
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
      end
   end
   // Storage needs no reset: evt_data is forced to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (reset && accept) mem[wr_ptr] <= evt_in;
   end
   assign evt_valid = used != '0;
   assign evt_data  = evt_valid ? mem[rd_ptr] : '0;
endmodule
